// File: rtl/lfsr_encrypt.sv
// LFSR stream cipher: writes a PAD preamble followed by the plaintext message, each byte
// XORed with a 6-bit LFSR keystream, into ciphertext memory at one byte per cycle.
module lfsr_encrypt #(
    parameter logic [7:0] MSG_BASE = 8'd0,
    parameter logic [7:0] CT_BASE  = 8'd64,
    parameter int unsigned LEN     = 64,
    parameter logic [7:0] PAD      = 8'h5F
) (
    input  logic       clk,
    input  logic       init,
    input  logic       start,
    input  logic [2:0] taps_sel,
    input  logic [5:0] seed,
    input  logic [3:0] pre_len,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] LastK = 8'(LEN - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] k_q, k_d;
    logic [5:0] lfsr_q, lfsr_d;
    logic [5:0] taps_q, taps_d;
    logic [3:0] pre_len_q, pre_len_d;

    logic [5:0] taps_dec;
    logic [5:0] seed_fix;
    logic [3:0] pre_len_clamp;
    logic [7:0] pre_len_ext;
    logic [7:0] plain;

    // Decode the start-time configuration into the values that get latched.
    always_comb begin
        case (taps_sel)
            3'd0:    taps_dec = 6'h21;
            3'd1:    taps_dec = 6'h2D;
            3'd2:    taps_dec = 6'h30;
            3'd3:    taps_dec = 6'h33;
            3'd4:    taps_dec = 6'h36;
            3'd5:    taps_dec = 6'h39;
            default: taps_dec = 6'h21;
        endcase
        // An all-zero state would lock the LFSR forever.
        seed_fix = (seed == 6'h00) ? 6'h01 : seed;
        if (pre_len < 4'd7) begin
            pre_len_clamp = 4'd7;
        end else if (pre_len > 4'd12) begin
            pre_len_clamp = 4'd12;
        end else begin
            pre_len_clamp = pre_len;
        end
    end

    // State register; init wins over any other activity in the same cycle.
    always_ff @(posedge clk) begin
        if (init) begin
            state_q   <= StIdle;
            k_q       <= 8'd0;
            lfsr_q    <= 6'd0;
            taps_q    <= 6'd0;
            pre_len_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            lfsr_q    <= lfsr_d;
            taps_q    <= taps_d;
            pre_len_q <= pre_len_d;
        end
    end

    // Next-state logic: accept start only in idle, step the LFSR and byte index in run.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        lfsr_d    = lfsr_q;
        taps_d    = taps_q;
        pre_len_d = pre_len_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    k_d       = 8'd0;
                    lfsr_d    = seed_fix;
                    taps_d    = taps_dec;
                    pre_len_d = pre_len_clamp;
                end
            end
            StRun: begin
                lfsr_d = {lfsr_q[4:0], ^(lfsr_q & taps_q)};
                if (k_q == LastK) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: memory interface is active only in run and held at zero otherwise.
    always_comb begin
        wr_en       = 1'b0;
        wr_addr     = 8'd0;
        wr_data     = 8'd0;
        rd_addr     = 8'd0;
        busy        = (state_q == StRun);
        done        = (state_q == StDone);
        pre_len_ext = {4'd0, pre_len_q};
        plain       = PAD;
        if (state_q == StRun) begin
            wr_en   = 1'b1;
            wr_addr = CT_BASE + k_q;
            if (k_q >= pre_len_ext) begin
                rd_addr = MSG_BASE + (k_q - pre_len_ext);
                plain   = rd_data;
            end else begin
                rd_addr = MSG_BASE;
                plain   = PAD;
            end
            wr_data = plain ^ {2'b00, lfsr_q};
        end
    end

endmodule

// File: tb/tb_lfsr_encrypt.sv
// Bench for lfsr_encrypt: scenario tasks checked against a keystream model of the cipher.
module tb_lfsr_encrypt;

    localparam int         LEN      = 64;
    localparam logic [7:0] CT_BASE  = 8'd64;
    localparam logic [7:0] MSG_BASE = 8'd0;
    localparam logic [7:0] PAD      = 8'h5F;

    logic       clk;
    logic       init;
    logic       start;
    logic [2:0] taps_sel;
    logic [5:0] seed;
    logic [3:0] pre_len;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;

    logic [7:0] pmem   [0:255];
    logic [7:0] ct_mem [0:255];
    logic [7:0] wlog   [0:4095];
    logic [7:0] exp_ct [0:63];
    logic [7:0] snap   [0:63];
    int         wr_cnt   = 0;
    int         done_cnt = 0;
    int         total    = 0;
    int         bad      = 0;

    lfsr_encrypt #(
        .MSG_BASE(MSG_BASE),
        .CT_BASE (CT_BASE),
        .LEN     (LEN),
        .PAD     (PAD)
    ) dut (
        .clk     (clk),
        .init    (init),
        .start   (start),
        .taps_sel(taps_sel),
        .seed    (seed),
        .pre_len (pre_len),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    assign rd_data = pmem[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ciphertext memory and write/done recorders.
    always @(posedge clk) begin
        if (wr_en) begin
            ct_mem[wr_addr]   <= wr_data;
            wlog[wr_cnt[11:0]] <= wr_addr;
            wr_cnt            <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int tap_of(input int ts);
        case (ts)
            0: return 'h21;
            1: return 'h2D;
            2: return 'h30;
            3: return 'h33;
            4: return 'h36;
            5: return 'h39;
            default: return 'h21;
        endcase
    endfunction

    function automatic int eff_seed(input int sd);
        return (sd == 0) ? 1 : sd;
    endfunction

    function automatic int eff_pre(input int pl);
        return (pl < 7) ? 7 : ((pl > 12) ? 12 : pl);
    endfunction

    // Keystream step: shift left by one (6 bits), feed in the parity of the tapped bits.
    function automatic int step(input int s, input int t);
        return ((s * 2) % 64) + ($countones(s & t) % 2);
    endfunction

    task automatic build_model(input int ts, input int sd, input int pl);
        int s, t, pre;
        logic [7:0] p;
        s   = eff_seed(sd);
        t   = tap_of(ts);
        pre = eff_pre(pl);
        for (int k = 0; k < LEN; k++) begin
            p         = (k < pre) ? PAD : pmem[(int'(MSG_BASE) + k - pre) % 256];
            exp_ct[k] = p ^ 8'(s);
            s         = step(s, t);
        end
    endtask

    // Pulse start with the given configuration and follow the run until done (bounded).
    task automatic do_run(input int ts, input int sd, input int pl,
                          output int busy_cycles, output int done_at);
        busy_cycles = 0;
        done_at     = -1;
        taps_sel    = 3'(ts);
        seed        = 6'(sd);
        pre_len     = 4'(pl);
        start       = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (busy) busy_cycles++;
            if (done && done_at < 0) done_at = n;
            if (done_at > 0) break;
        end
        tick();
    endtask

    task automatic test_reset();
        init  = 1'b1;
        start = 1'b0;
        tick();
        tick();
        total++;
        if ({busy, done, wr_en} !== 3'b000 || wr_addr !== 8'd0 || wr_data !== 8'd0
            || rd_addr !== 8'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b wr_en=%b wr_addr=%h wr_data=%h rd_addr=%h want all 0",
                     busy, done, wr_en, wr_addr, wr_data, rd_addr);
        end
        init = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b wr_en=%b want 0 0", busy, wr_en);
        end
    endtask

    task automatic test_basic();
        int bc, da, w0, d0, errs;
        for (int i = 0; i < 256; i++) pmem[i] = 8'($urandom);
        w0 = wr_cnt;
        d0 = done_cnt;
        do_run(0, 1, 7, bc, da);
        total++;
        if (ct_mem[64] !== 8'h5E || ct_mem[65] !== 8'h5C || ct_mem[66] !== 8'h58) begin
            bad++;
            $display("FAIL basic_first_bytes: got %h %h %h want 5e 5c 58",
                     ct_mem[64], ct_mem[65], ct_mem[66]);
        end
        total++;
        if (bc !== 64) begin
            bad++;
            $display("FAIL basic_busy_cycles: got %0d want 64", bc);
        end
        total++;
        if (da !== 65) begin
            bad++;
            $display("FAIL basic_done_cycle: got %0d want 65", da);
        end
        total++;
        if (wr_cnt - w0 !== 64 || done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL basic_counts: writes=%0d dones=%0d want 64 1", wr_cnt - w0, done_cnt - d0);
        end
        errs = 0;
        for (int k = 0; k < 64; k++) if (wlog[(w0 + k) % 4096] !== 8'(64 + k)) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL basic_addr_seq: %0d wrong addresses want 64..127 in order", errs);
        end
        build_model(0, 1, 7);
        errs = 0;
        for (int k = 0; k < 64; k++) if (ct_mem[64 + k] !== exp_ct[k]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL basic_ciphertext: %0d bytes differ want 0", errs);
        end
        total++;
        if (wr_en !== 1'b0 || wr_addr !== 8'd0 || wr_data !== 8'd0 || rd_addr !== 8'd0 || busy) begin
            bad++;
            $display("FAIL basic_idle_outputs: wr_en=%b wr_addr=%h wr_data=%h rd_addr=%h busy=%b want 0",
                     wr_en, wr_addr, wr_data, rd_addr, busy);
        end
    endtask

    task automatic test_roundtrip();
        int bc, da, sd, s, errs;
        logic [7:0] dec, want;
        for (int i = 0; i < 57; i++) pmem[i] = 8'(65 + i);
        for (int ts = 0; ts < 6; ts++) begin
            sd = int'($urandom_range(0, 63));
            do_run(ts, sd, 7, bc, da);
            s    = eff_seed(sd);
            errs = 0;
            for (int k = 0; k < 64; k++) begin
                dec  = ct_mem[64 + k] ^ 8'(s);
                want = (k < 7) ? 8'h5F : 8'(65 + k - 7);
                if (dec !== want) errs++;
                s = step(s, tap_of(ts));
            end
            total++;
            if (errs != 0 || da !== 65) begin
                bad++;
                $display("FAIL roundtrip_taps%0d: %0d bytes wrong done_at=%0d want 0 65", ts, errs, da);
            end
        end
        // Random configurations including out-of-range pre_len and taps_sel 6/7.
        for (int it = 0; it < 4; it++) begin
            int ts, pl;
            for (int i = 0; i < 256; i++) pmem[i] = 8'($urandom);
            ts = int'($urandom_range(0, 7));
            sd = int'($urandom_range(0, 63));
            pl = int'($urandom_range(0, 15));
            do_run(ts, sd, pl, bc, da);
            build_model(ts, sd, pl);
            errs = 0;
            for (int k = 0; k < 64; k++) if (ct_mem[64 + k] !== exp_ct[k]) errs++;
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL random_cfg ts=%0d seed=%0d pre=%0d: %0d bytes differ want 0",
                         ts, sd, pl, errs);
            end
        end
    endtask

    task automatic test_boundaries();
        int pa [0:3][0:2];
        int pb [0:3][0:2];
        int bc, da, errs, merrs;
        pa[0] = '{0, 0, 7};  pb[0] = '{0, 1, 7};
        pa[1] = '{0, 5, 3};  pb[1] = '{0, 5, 7};
        pa[2] = '{2, 9, 15}; pb[2] = '{2, 9, 12};
        pa[3] = '{7, 9, 8};  pb[3] = '{0, 9, 8};
        for (int i = 0; i < 256; i++) pmem[i] = 8'($urandom);
        for (int c = 0; c < 4; c++) begin
            do_run(pa[c][0], pa[c][1], pa[c][2], bc, da);
            for (int k = 0; k < 64; k++) snap[k] = ct_mem[64 + k];
            do_run(pb[c][0], pb[c][1], pb[c][2], bc, da);
            build_model(pb[c][0], pb[c][1], pb[c][2]);
            errs  = 0;
            merrs = 0;
            for (int k = 0; k < 64; k++) begin
                if (snap[k] !== ct_mem[64 + k]) errs++;
                if (ct_mem[64 + k] !== exp_ct[k]) merrs++;
            end
            total++;
            if (errs != 0 || merrs != 0) begin
                bad++;
                $display("FAIL boundary_case%0d: %0d pair diffs %0d model diffs want 0 0",
                         c, errs, merrs);
            end
        end
    endtask

    task automatic test_start_ignored();
        int w0, d0, sd, errs;
        for (int i = 0; i < 256; i++) pmem[i] = 8'($urandom);
        sd       = int'($urandom_range(1, 63));
        w0       = wr_cnt;
        d0       = done_cnt;
        taps_sel = 3'd3;
        seed     = 6'(sd);
        pre_len  = 4'd9;
        start    = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            tick();
            start = (n == 11) || done;
        end
        start = 1'b0;
        tick();
        build_model(3, sd, 9);
        errs = 0;
        for (int k = 0; k < 64; k++) if (ct_mem[64 + k] !== exp_ct[k]) errs++;
        total++;
        if (wr_cnt - w0 !== 64 || done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL start_ignored_counts: writes=%0d dones=%0d want 64 1",
                     wr_cnt - w0, done_cnt - d0);
        end
        total++;
        if (errs != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored_data: %0d bytes differ busy=%b want 0 0", errs, busy);
        end
    endtask

    task automatic test_init_abort();
        int w0, d0, bc, da, errs;
        logic wr_en_after, busy_after;
        for (int i = 0; i < 256; i++) pmem[i] = 8'($urandom);
        w0          = wr_cnt;
        d0          = done_cnt;
        wr_en_after = 1'bx;
        busy_after  = 1'bx;
        taps_sel    = 3'd1;
        seed        = 6'h2A;
        pre_len     = 4'd10;
        start       = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            tick();
            start = 1'b0;
            if (n == 21) init = 1'b1;
            if (n == 22) begin
                wr_en_after = wr_en;
                busy_after  = busy;
                init        = 1'b0;
            end
        end
        total++;
        if (wr_en_after !== 1'b0 || busy_after !== 1'b0) begin
            bad++;
            $display("FAIL abort_outputs: wr_en=%b busy=%b want 0 0", wr_en_after, busy_after);
        end
        total++;
        if (wr_cnt - w0 !== 21 || done_cnt - d0 !== 0) begin
            bad++;
            $display("FAIL abort_counts: writes=%0d dones=%0d want 21 0", wr_cnt - w0, done_cnt - d0);
        end
        w0 = wr_cnt;
        do_run(4, 17, 11, bc, da);
        build_model(4, 17, 11);
        errs = 0;
        for (int k = 0; k < 64; k++) begin
            if (ct_mem[64 + k] !== exp_ct[k]) errs++;
            if (wlog[(w0 + k) % 4096] !== 8'(64 + k)) errs++;
        end
        total++;
        if (errs != 0 || wr_cnt - w0 !== 64 || da !== 65) begin
            bad++;
            $display("FAIL rerun_after_abort: errs=%0d writes=%0d done_at=%0d want 0 64 65",
                     errs, wr_cnt - w0, da);
        end
    endtask

    task automatic test_init_start_same();
        int w0, d0, busy_seen;
        w0        = wr_cnt;
        d0        = done_cnt;
        busy_seen = 0;
        taps_sel  = 3'd0;
        seed      = 6'h01;
        pre_len   = 4'd7;
        init      = 1'b1;
        start     = 1'b1;
        tick();
        init  = 1'b0;
        start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (busy || wr_en) busy_seen++;
        end
        total++;
        if (busy_seen != 0 || wr_cnt - w0 !== 0 || done_cnt - d0 !== 0) begin
            bad++;
            $display("FAIL init_start_same: active=%0d writes=%0d dones=%0d want 0 0 0",
                     busy_seen, wr_cnt - w0, done_cnt - d0);
        end
    endtask

    initial begin
        init     = 1'b1;
        start    = 1'b0;
        taps_sel = 3'd0;
        seed     = 6'd0;
        pre_len  = 4'd0;
        for (int i = 0; i < 256; i++) begin
            pmem[i]   = 8'd0;
            ct_mem[i] = 8'd0;
        end
        test_reset();
        test_basic();
        test_roundtrip();
        test_boundaries();
        test_start_ignored();
        test_init_abort();
        test_init_start_same();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_encrypt.md
LFSR_ENCRYPT -- requirements
Module: lfsr_encrypt

Interface
REQ-001 SHALL have parameter MSG_BASE, default 8'd0, plaintext start address.
REQ-002 SHALL have parameter CT_BASE, default 8'd64, ciphertext start address.
REQ-003 SHALL have parameter LEN, default 64, total ciphertext bytes (preamble + message).
REQ-004 SHALL have parameter PAD, default 8'h5F, preamble plaintext character.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port init  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  single-cycle request to begin an encryption run.
REQ-008 SHALL have port taps_sel  input  3  tap-pattern index, sampled on accepted start.
REQ-009 SHALL have port seed  input  6  LFSR starting state, sampled on accepted start.
REQ-010 SHALL have port pre_len  input  4  preamble length in bytes, sampled on accepted start.
REQ-011 SHALL have port rd_addr  output  8  plaintext memory read address.
REQ-012 SHALL have port rd_data  input  8  plaintext byte; combinational read, valid in the same cycle as rd_addr.
REQ-013 SHALL have port wr_en  output  1  ciphertext memory write strobe; the write occurs on the next rising edge.
REQ-014 SHALL have port wr_addr  output  8  ciphertext write address.
REQ-015 SHALL have port wr_data  output  8  ciphertext byte.
REQ-016 SHALL have port busy  output  1  high while a run is in progress.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, RUN and DONE; IDLE->RUN on start=1; RUN->DONE after byte index k=LEN-1; DONE->IDLE unconditionally after one cycle.
REQ-019 SHALL on an accepted start latch the tap pattern, seed and pre_len, set k=0, and load the LFSR with the latched seed.
REQ-020 SHALL map taps_sel 0..5 to 6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39, and SHALL map taps_sel 6 or 7 to 6'h21.
REQ-021 SHALL substitute seed 6'h00 with 6'h01, so the LFSR cannot lock up.
REQ-022 SHALL clamp pre_len to the range 7..12: values below 7 become 7; values above 12 become 12.
REQ-023 SHALL advance the LFSR once per RUN cycle: next = {state[4:0], ^(state & taps)}.
REQ-024 SHALL in each RUN cycle assert wr_en=1 with wr_addr = CT_BASE + k.
REQ-025 SHALL during RUN drive wr_data = P ^ {2'b00, lfsr}, where P = PAD for k < pre_len and P = rd_data otherwise.
REQ-026 SHALL drive rd_addr = MSG_BASE + (k - pre_len) for k >= pre_len, and rd_addr = MSG_BASE otherwise.
REQ-027 SHALL write exactly LEN bytes per run, at one byte per cycle, with no gaps.
REQ-028 SHALL drive busy = 1 in RUN only.
REQ-029 SHALL drive done = 1 in DONE only, one cycle after the final write.
REQ-030 SHALL ignore start while in RUN or DONE; a start in DONE is not queued.
REQ-031 SHALL drive wr_en = 0 outside RUN, and SHALL hold wr_addr, wr_data and rd_addr at 0 outside RUN.
REQ-032 SHALL wrap address arithmetic modulo 256.

Reset
REQ-033 SHALL on init=1 enter IDLE with k=0, LFSR=0, latched config=0, busy=0, done=0, wr_en=0, rd_addr=0, wr_addr=0 and wr_data=0.
REQ-034 SHALL give init priority over start in the same cycle.
REQ-035 SHALL on init asserted mid-RUN abort the run with no further writes; ciphertext already written is not restored.

Verification
REQ-036 SHALL cover a basic run: taps_sel=0, seed=6'h01, pre_len=7, start -> writes to addr 64, 65, 66 = 8'h5E, 8'h5C, 8'h58; busy high for 64 cycles; done pulses at cycle 65.
REQ-037 SHALL cover a decrypt round-trip for all six taps_sel values: mem[0..56]='A'..; run the encryption; decrypt with the same LFSR -> recovered bytes match the plaintext, and mem[64..70] decrypts to 8'h5F.
REQ-038 SHALL cover boundaries: seed=0 gives the same output as seed=1; pre_len=3 gives the same output as pre_len=7; pre_len=15 gives the same output as pre_len=12; taps_sel=7 gives the same output as taps_sel=0.
REQ-039 SHALL cover start pulsed at k=10 and again during DONE -> no restart, exactly 64 writes, a single done pulse.
REQ-040 SHALL cover init at k=20 -> wr_en=0 from the next cycle, busy=0, done never asserted; a new start then runs a full 64-byte sequence from addr 64.
REQ-041 SHALL cover init and start high in the same cycle -> remains in IDLE with no writes.
